subbytes_iter: RTL

SUBBYTES_ITER -- requirements
Module: subbytes_iter

---
 rtl/subbytes_iter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/subbytes_iter.sv
// subbytes_iter: iterative AES SubBytes over a 128-bit state, LANES bytes per cycle.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/mode/data_in  - input block handshake
//   out_valid/out_ready/data_out    - result handshake
//   busy                            - FSM not idle
// Optional feature: define SUBBYTES_INV_SBOX_EN to add inverse S-box lanes
// selected by mode.  Without it mode is ignored and the forward S-box is used.
module subbytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Row r of each table holds entries 16r..16r+15, entry 0 leftmost.
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBBYTES_INV_SBOX_EN
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  logic mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  st;
  logic [127:0]  nxt;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  // Lane l works on byte cnt*LANES + l of the state.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = st[8*(int'(cnt)*LANES + l) +: 8];
`ifdef SUBBYTES_INV_SBOX_EN
    assign lane_out[l] = mode_q ? INV[lane_in[l]]
                                : FWD[lane_in[l]];
`else
    assign lane_out[l] = FWD[lane_in[l]];
`endif
  end

  always_comb begin
    nxt = st;
    for (int l = 0; l < LANES; l++) begin
      nxt[8*(int'(cnt)*LANES + l) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      st        <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef SUBBYTES_INV_SBOX_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= data_in;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SUBBYTES_INV_SBOX_EN
            mode_q   <= mode;
`endif
          end
        end
        RUN: begin
          st <= nxt;
          if (cnt == CW'(STEPS - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            data_out  <= nxt;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
